// File: rtl/chan_rr_arbiter.sv
// ----------------------------------------------------------------------------
// chan_rr_arbiter
//
// Round-robin readout scheduler that shares GTP lane 0 between the NCH
// per-channel processors of one channel FPGA. One requester is granted at a
// time and its block (header + N payload words) is streamed word by word onto
// the lane. Idle cycles carry COMMA. A sum-trigger pulse preempts the stream
// with a KTRIG K-character on the following lane word.
//
// Optional feature (compile-time macro CHAN_ARB_TRAILER_EN):
//   When defined, every block is followed by one trailer word (kchar=0)
//   holding the XOR of all block words, header included.
//
// Ports:
//   clk      in   125 MHz master clock, all logic on its rising edge
//   rst_n    in   synchronous active-low reset
//   data     in   16*NCH flattened channel words, word i = data[16*i +: 16]
//   req      in   NCH level requests, channel i has a complete block pending
//   ack      out  NCH one-hot read strobe, channel advances after each ack cycle
//   trigger  in   sum trigger, one KTRIG per asserted cycle
//   dout     out  16-bit lane word
//   kchar    out  dout is a K-character
//   busy     out  a block is in progress
// ----------------------------------------------------------------------------
module chan_rr_arbiter #(
    parameter int          NCH   = 16,
    parameter logic [15:0] COMMA = 16'hC5BC,
    parameter logic [15:0] KTRIG = 16'h7C7C
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [16*NCH-1:0] data,
    input  logic [NCH-1:0]    req,
    output logic [NCH-1:0]    ack,
    input  logic              trigger,
    output logic [15:0]       dout,
    output logic              kchar,
    output logic              busy
);

    localparam int PW = (NCH > 1) ? $clog2(NCH) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HDR  = 2'd1,
        S_DATA = 2'd2,
        S_TRL  = 2'd3
    } state_t;

    state_t            r_state;
    logic [PW-1:0]     r_ptr;
    logic [PW-1:0]     r_gnt;
    logic [7:0]        r_cnt;
    logic [NCH-1:0]    r_ack;
    logic [15:0]       r_dout;
    logic              r_kchar;
    logic              r_busy;
    // A word consumed in a trigger cycle is parked here until the lane is free.
    logic [15:0]       r_hold;
    logic              r_pend;
`ifdef CHAN_ARB_TRAILER_EN
    logic [15:0]       r_xor;
`endif

    logic [15:0]       w_word;
    logic              w_take;
    logic              w_last;
    logic              w_grant;
    logic [PW-1:0]     w_sel;
    logic [PW-1:0]     w_ptr_nxt;
    logic              w_to_idle;
    logic              w_active_nxt;
    logic              w_word_out;
    logic              w_pend_nxt;

    // First set request searching upward from base, wrapping at NCH.
    function automatic logic [PW-1:0] f_first(input logic [NCH-1:0] r,
                                              input logic [PW-1:0]  base);
        logic [PW-1:0] sel;
        logic          found;
        int            idx;
        sel   = '0;
        found = 1'b0;
        for (int k = 0; k < NCH; k++) begin
            idx = (int'(base) + k) % NCH;
            if (!found && r[idx]) begin
                sel   = PW'(idx);
                found = 1'b1;
            end
        end
        return sel;
    endfunction

    function automatic logic [NCH-1:0] f_onehot(input logic [PW-1:0] idx);
        logic [NCH-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    assign w_word    = data[16*r_gnt +: 16];
    // A word is consumed on every cycle the registered ack is high.
    assign w_take    = |r_ack;
    assign w_last    = w_take && (((r_state == S_HDR)  && (w_word[7:0] == 8'd0)) ||
                                  ((r_state == S_DATA) && (r_cnt == 8'd1)));
    // A parked word must reach the lane before a new block may start.
    assign w_grant   = (r_state == S_IDLE) && !trigger && !r_pend && (|req);
    assign w_sel     = f_first(req, r_ptr);
    assign w_ptr_nxt = (r_gnt == PW'(NCH-1)) ? '0 : r_gnt + PW'(1);

`ifdef CHAN_ARB_TRAILER_EN
    assign w_to_idle  = (r_state == S_TRL) && !trigger && !r_pend;
    assign w_word_out = !trigger && (r_pend || w_take || (r_state == S_TRL));
`else
    assign w_to_idle  = w_last;
    assign w_word_out = !trigger && (r_pend || w_take);
`endif

    assign w_active_nxt = w_grant || ((r_state != S_IDLE) && !w_to_idle);
    assign w_pend_nxt   = trigger && (r_pend || w_take);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_ptr   <= '0;
            r_gnt   <= '0;
            r_cnt   <= '0;
            r_ack   <= '0;
            r_dout  <= COMMA;
            r_kchar <= 1'b1;
            r_busy  <= 1'b0;
            r_pend  <= 1'b0;
        end else begin
            // Control: ack is re-derived every cycle and held low after a trigger.
            r_ack <= '0;
            case (r_state)
                S_IDLE: begin
                    if (w_grant) begin
                        r_gnt   <= w_sel;
                        r_ack   <= f_onehot(w_sel);
                        r_state <= S_HDR;
`ifdef CHAN_ARB_TRAILER_EN
                        r_xor   <= '0;
`endif
                    end
                end
                S_HDR, S_DATA: begin
                    if (w_take)
                        r_cnt <= (r_state == S_HDR) ? w_word[7:0] : r_cnt - 8'd1;
                    if (w_last) begin
                        // Block end: ptr moves past the granted channel on the
                        // edge that consumes the final word.
                        r_ptr   <= w_ptr_nxt;
`ifdef CHAN_ARB_TRAILER_EN
                        r_state <= S_TRL;
`else
                        r_state <= S_IDLE;
`endif
                    end else begin
                        if (w_take && (r_state == S_HDR))
                            r_state <= S_DATA;
                        if (!trigger)
                            r_ack <= f_onehot(r_gnt);
                    end
                end
`ifdef CHAN_ARB_TRAILER_EN
                S_TRL: begin
                    if (w_to_idle)
                        r_state <= S_IDLE;
                end
`endif
                default: r_state <= S_IDLE;
            endcase

`ifdef CHAN_ARB_TRAILER_EN
            if (w_take)
                r_xor <= r_xor ^ w_word;
`endif

            // Lane word: trigger > parked word > fresh word > trailer > comma.
            r_pend <= w_pend_nxt;
            if (trigger) begin
                r_dout  <= KTRIG;
                r_kchar <= 1'b1;
                if (w_take)
                    r_hold <= w_word;
            end else if (r_pend) begin
                r_dout  <= r_hold;
                r_kchar <= 1'b0;
            end else if (w_take) begin
                r_dout  <= w_word;
                r_kchar <= 1'b0;
`ifdef CHAN_ARB_TRAILER_EN
            end else if (r_state == S_TRL) begin
                r_dout  <= r_xor;
                r_kchar <= 1'b0;
`endif
            end else begin
                r_dout  <= COMMA;
                r_kchar <= 1'b1;
            end

            r_busy <= w_active_nxt || w_word_out || w_pend_nxt;
        end
    end

    assign ack   = r_ack;
    assign dout  = r_dout;
    assign kchar = r_kchar;
    assign busy  = r_busy;

endmodule

// File: tb/tb_chan_rr_arbiter.sv
module tb_chan_rr_arbiter;

    localparam int NCH = 16;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [16*NCH-1:0] data;
    logic [NCH-1:0]    req;
    logic [NCH-1:0]    ack;
    logic              trigger;
    logic [15:0]       dout;
    logic              kchar;
    logic              busy;

    int n_chk  = 0;
    int n_fail = 0;

    // Behavioural channel sources: each channel presents mem[i][pos[i]] and
    // advances after every cycle its ack bit is high.
    logic [15:0] mem [NCH][260];
    int          pos [NCH] = '{default: 0};
    logic        pos_clr;

    always #4 clk = ~clk;

    always @(posedge clk) begin
        for (int i = 0; i < NCH; i++) begin
            if (pos_clr)
                pos[i] <= 0;
            else if (ack[i] && pos[i] < 259)
                pos[i] <= pos[i] + 1;
        end
    end

    always_comb begin
        for (int i = 0; i < NCH; i++)
            data[16*i +: 16] = mem[i][pos[i]];
    end

    chan_rr_arbiter #(.NCH(NCH), .COMMA(16'hC5BC), .KTRIG(16'h7C7C)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .data    (data),
        .req     (req),
        .ack     (ack),
        .trigger (trigger),
        .dout    (dout),
        .kchar   (kchar),
        .busy    (busy)
    );

    task automatic do_reset;
        @(negedge clk);
        rst_n   = 1'b0;
        pos_clr = 1'b1;
        req     = '0;
        trigger = 1'b0;
        @(negedge clk);
        rst_n   = 1'b1;
        pos_clr = 1'b0;
    endtask

    task automatic test_reset;
        rst_n   = 1'b0;
        pos_clr = 1'b1;
        req     = 16'hFFFF;
        trigger = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            n_chk++;
            if ({ack, dout, kchar, busy} !== {16'h0000, 16'hC5BC, 1'b1, 1'b0}) begin
                n_fail++;
                $display("FAIL reset_hold cyc%0d: ack=%h dout=%h k=%b busy=%b, expected ack=0000 dout=c5bc k=1 busy=0",
                         c, ack, dout, kchar, busy);
            end
        end
        rst_n   = 1'b1;
        pos_clr = 1'b0;
        req     = '0;
    endtask

    task automatic test_single_block;
        logic [15:0] e_ack  [6];
        logic [15:0] e_dout [6];
        logic        e_k    [6];
        logic        e_b    [6];
        int          ncyc;
        mem[3][0] = 16'h8302;
        mem[3][1] = 16'h0011;
        mem[3][2] = 16'h0022;
        e_ack = '{16'h0008, 16'h0008, 16'h0008, 16'h0000, 16'h0000, 16'h0000};
        e_dout = '{16'hC5BC, 16'h8302, 16'h0011, 16'h0022, 16'hC5BC, 16'hC5BC};
        e_k = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        e_b = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        ncyc = 5;
`ifdef CHAN_ARB_TRAILER_EN
        e_dout[4] = 16'h8331;
        e_k[4]    = 1'b0;
        e_b[4]    = 1'b1;
        ncyc      = 6;
`endif
        do_reset();
        req = 16'h0008;
        for (int c = 0; c < ncyc; c++) begin
            @(negedge clk);
            req = '0;
            n_chk++;
            if ({ack, dout, kchar, busy} !== {e_ack[c], e_dout[c], e_k[c], e_b[c]}) begin
                n_fail++;
                $display("FAIL single_block cyc%0d: ack=%h dout=%h k=%b busy=%b, expected ack=%h dout=%h k=%b busy=%b",
                         c + 1, ack, dout, kchar, busy, e_ack[c], e_dout[c], e_k[c], e_b[c]);
            end
        end
    endtask

    task automatic test_round_robin;
        logic [15:0] e_ack;
        logic [15:0] e_dout;
        logic        e_k;
        for (int j = 0; j < 2; j++) begin
            mem[0][j]  = {8'h10 + 8'(j), 8'h00};
            mem[15][j] = {8'hF0 + 8'(j), 8'h00};
        end
        do_reset();
        req = 16'h8001;
        for (int b = 0; b < 4; b++) begin
            for (int h = 0; h < 2; h++) begin
                @(negedge clk);
                if (h == 0) begin
                    e_ack  = (b % 2 == 0) ? 16'h0001 : 16'h8000;
                    e_dout = 16'hC5BC;
                    e_k    = 1'b1;
                end else begin
                    e_ack  = 16'h0000;
                    e_dout = {((b % 2 == 0) ? 8'h10 : 8'hF0) + 8'(b / 2), 8'h00};
                    e_k    = 1'b0;
                end
                n_chk++;
                if ({ack, dout, kchar, busy} !== {e_ack, e_dout, e_k, 1'b1}) begin
                    n_fail++;
                    $display("FAIL round_robin blk%0d ph%0d: ack=%h dout=%h k=%b busy=%b, expected ack=%h dout=%h k=%b busy=1",
                             b, h, ack, dout, kchar, busy, e_ack, e_dout, e_k);
                end
            end
        end
        req = '0;
    endtask

    task automatic test_trigger_mid_block;
        logic [15:0] e_ack  [8];
        logic [15:0] e_dout [8];
        logic        e_k    [8];
        logic        e_b    [8];
        mem[5][0] = 16'h8503;
        mem[5][1] = 16'hA001;
        mem[5][2] = 16'hA002;
        mem[5][3] = 16'hA003;
        e_ack  = '{16'h0020, 16'h0020, 16'h0000, 16'h0000, 16'h0020, 16'h0020, 16'h0000, 16'h0000};
        e_dout = '{16'hC5BC, 16'h8503, 16'h7C7C, 16'h7C7C, 16'hA001, 16'hA002, 16'hA003, 16'hC5BC};
        e_k    = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        e_b    = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
`ifdef CHAN_ARB_TRAILER_EN
        e_dout[7] = 16'h2503;
        e_k[7]    = 1'b0;
        e_b[7]    = 1'b1;
`endif
        do_reset();
        req = 16'h0020;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (c == 0) req = '0;
            if (c == 1) trigger = 1'b1;
            if (c == 3) trigger = 1'b0;
            n_chk++;
            if ({ack, dout, kchar, busy} !== {e_ack[c], e_dout[c], e_k[c], e_b[c]}) begin
                n_fail++;
                $display("FAIL trigger_mid cyc%0d: ack=%h dout=%h k=%b busy=%b, expected ack=%h dout=%h k=%b busy=%b",
                         c + 1, ack, dout, kchar, busy, e_ack[c], e_dout[c], e_k[c], e_b[c]);
            end
        end
    endtask

    task automatic test_trigger_idle;
        logic [15:0] e_ack  [3];
        logic [15:0] e_dout [3];
        logic        e_k    [3];
        logic        e_b    [3];
        mem[2][0] = 16'h0200;
        e_ack  = '{16'h0000, 16'h0004, 16'h0000};
        e_dout = '{16'h7C7C, 16'hC5BC, 16'h0200};
        e_k    = '{1'b1, 1'b1, 1'b0};
        e_b    = '{1'b0, 1'b1, 1'b1};
        do_reset();
        req     = 16'h0004;
        trigger = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            trigger = 1'b0;
            if (c == 1) req = '0;
            n_chk++;
            if ({ack, dout, kchar, busy} !== {e_ack[c], e_dout[c], e_k[c], e_b[c]}) begin
                n_fail++;
                $display("FAIL trigger_idle cyc%0d: ack=%h dout=%h k=%b busy=%b, expected ack=%h dout=%h k=%b busy=%b",
                         c + 1, ack, dout, kchar, busy, e_ack[c], e_dout[c], e_k[c], e_b[c]);
            end
        end
    endtask

    task automatic test_wrap_n255;
        int          bad;
        int          n_hi;
        logic [15:0] e_dout;
        mem[15][0] = 16'h0FFF;
        for (int k = 1; k < 256; k++)
            mem[15][k] = 16'(k);
        mem[1][0] = 16'h1100;
        do_reset();
        req  = 16'h8000;
        bad  = 0;
        n_hi = 0;
        @(negedge clk);
        n_chk++;
        if ({ack, dout, kchar, busy} !== {16'h8000, 16'hC5BC, 1'b1, 1'b1}) begin
            n_fail++;
            $display("FAIL n255_grant: ack=%h dout=%h k=%b busy=%b, expected ack=8000 dout=c5bc k=1 busy=1",
                     ack, dout, kchar, busy);
        end
        if (ack[15]) n_hi++;
        req = 16'h8006;
        for (int c = 2; c <= 256; c++) begin
            @(negedge clk);
            if (ack[15]) n_hi++;
            e_dout = (c == 2) ? 16'h0FFF : 16'(c - 2);
            if ({ack, dout, kchar, busy} !== {16'h8000, e_dout, 1'b0, 1'b1}) bad++;
        end
        n_chk++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL n255_stream: %0d bad cycles, required 0", bad);
        end
        @(negedge clk);
        if (ack[15]) n_hi++;
        n_chk++;
        if ({ack, dout, kchar, busy} !== {16'h0000, 16'h00FF, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL n255_last: ack=%h dout=%h k=%b busy=%b, expected ack=0000 dout=00ff k=0 busy=1",
                     ack, dout, kchar, busy);
        end
        n_chk++;
        if (n_hi != 256) begin
            n_fail++;
            $display("FAIL n255_ack_len: ack high %0d cycles, required 256", n_hi);
        end
`ifdef CHAN_ARB_TRAILER_EN
        @(negedge clk);
        n_chk++;
        if ({ack, dout, kchar, busy} !== {16'h0000, 16'h0FFF, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL n255_trailer: ack=%h dout=%h k=%b busy=%b, expected ack=0000 dout=0fff k=0 busy=1",
                     ack, dout, kchar, busy);
        end
`endif
        @(negedge clk);
        n_chk++;
        if ({ack, dout, kchar, busy} !== {16'h0002, 16'hC5BC, 1'b1, 1'b1}) begin
            n_fail++;
            $display("FAIL n255_wrap_grant: ack=%h dout=%h k=%b busy=%b, expected ack=0002 dout=c5bc k=1 busy=1",
                     ack, dout, kchar, busy);
        end
        req = '0;
    endtask

    task automatic test_reset_mid_block;
        logic [15:0] e_ack  [11];
        logic [15:0] e_dout [11];
        logic        e_k    [11];
        logic        e_b    [11];
        mem[9][0] = 16'h0900;
        mem[7][0] = 16'h0706;
        for (int k = 1; k <= 6; k++)
            mem[7][k] = 16'h7000 + 16'(k);
        e_ack  = '{16'h0200, 16'h0000, 16'h0000, 16'h0080, 16'h0080, 16'h0080,
                   16'h0080, 16'h0080, 16'h0080, 16'h0000, 16'h0080};
        e_dout = '{16'hC5BC, 16'h0900, 16'hC5BC, 16'hC5BC, 16'h0706, 16'h7001,
                   16'h7002, 16'h7003, 16'h7004, 16'hC5BC, 16'hC5BC};
        e_k    = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        e_b    = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
`ifdef CHAN_ARB_TRAILER_EN
        e_dout[2] = 16'h0900;
        e_k[2]    = 1'b0;
        e_b[2]    = 1'b1;
`endif
        do_reset();
        req = 16'h0200;
        for (int c = 0; c < 11; c++) begin
            @(negedge clk);
            if (c == 0) req = '0;
            if (c == 2) req = 16'h0080;
            if (c == 8) begin
                rst_n = 1'b0;
                req   = 16'h0480;
            end
            if (c == 9) rst_n = 1'b1;
            n_chk++;
            if ({ack, dout, kchar, busy} !== {e_ack[c], e_dout[c], e_k[c], e_b[c]}) begin
                n_fail++;
                $display("FAIL reset_mid cyc%0d: ack=%h dout=%h k=%b busy=%b, expected ack=%h dout=%h k=%b busy=%b",
                         c + 1, ack, dout, kchar, busy, e_ack[c], e_dout[c], e_k[c], e_b[c]);
            end
        end
        req = '0;
    endtask

    initial begin
        test_reset();
        test_single_block();
        test_round_robin();
        test_trigger_mid_block();
        test_trigger_idle();
        test_wrap_n255();
        test_reset_mid_block();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
